// File: rtl/rx_dat_fifo.sv
// rx_dat_fifo: elastic receive byte FIFO that regenerates CYC_O frame envelopes.
// Define RXDAT_FRMLEN_EN to add the FRM_LEN_O / FRM_END_O frame statistics.
module rx_dat_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [DW-1:0] DAT_I,
    input  logic          WE_I,
    input  logic          STB_I,
    input  logic          CYC_I,
    output logic          ACK_O,
    output logic [DW-1:0] DAT_O,
    output logic          WE_O,
    output logic          STB_O,
    output logic          CYC_O,
`ifdef RXDAT_FRMLEN_EN
    output logic [15:0]   FRM_LEN_O,
    output logic          FRM_END_O,
`endif
    input  logic          ACK_I
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {O_IDLE, O_FRM} ostate_e;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] tag_q;
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             cyc_q, has_q;
    logic             end_pend_q, end_pend_d;
    logic             gap_q, gap_d;
    ostate_e          state_q, state_d;

    logic          empty, full, wr_en, rd_en;
    logic          close, held, pop_tag, leave;
    logic [AW-1:0] wr_idx, rd_idx, last_idx;

    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign last_idx = wr_idx - AW'(1);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    assign ACK_O = ~full;
    assign STB_O = ~empty;
    assign WE_O  = STB_O;
    assign DAT_O = mem_q[rd_idx];

    assign wr_en   = CYC_I & STB_I & WE_I & ~full;
    assign rd_en   = STB_O & ACK_I;
    assign pop_tag = rd_en & tag_q[rd_idx];

    // A close racing the pop of the final byte counts as already drained.
    assign close = cyc_q & ~CYC_I & has_q;
    assign held  = ~empty &
                   ~(rd_en && ((rd_ptr_q + (AW+1)'(1)) == wr_ptr_q));

    always_comb begin
        state_d = state_q;
        leave   = 1'b0;
        CYC_O   = 1'b0;
        unique case (state_q)
            O_IDLE: begin
                if (STB_O && !gap_q) begin
                    CYC_O = 1'b1;
                    if (pop_tag) leave = 1'b1;
                    else state_d = O_FRM;
                end
            end
            O_FRM: begin
                CYC_O = ~end_pend_q;
                if (pop_tag || end_pend_q) begin
                    leave   = 1'b1;
                    state_d = O_IDLE;
                end
            end
            default: state_d = O_IDLE;
        endcase
        gap_d = leave;
    end

    always_comb begin
        end_pend_d = end_pend_q;
        if (state_q == O_FRM && end_pend_q) end_pend_d = 1'b0;
        if (close && !held) end_pend_d = 1'b1;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_q      <= '0;
            cyc_q      <= 1'b0;
            has_q      <= 1'b0;
            end_pend_q <= 1'b0;
            gap_q      <= 1'b0;
            state_q    <= O_IDLE;
        end else begin
            cyc_q      <= CYC_I;
            state_q    <= state_d;
            gap_q      <= gap_d;
            end_pend_q <= end_pend_d;
            if (wr_en) begin
                tag_q[wr_idx] <= 1'b0;
                wr_ptr_q      <= wr_ptr_q + (AW+1)'(1);
                has_q         <= 1'b1;
            end
            if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (close) begin
                if (held) tag_q[last_idx] <= 1'b1;
                has_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (wr_en) mem_q[wr_idx] <= DAT_I;
    end

`ifdef RXDAT_FRMLEN_EN
    logic [15:0] len_q, len_d;
    logic        end_q, start;

    assign start = (state_q == O_IDLE) & STB_O & ~gap_q;

    always_comb begin
        len_d = len_q;
        if (start) len_d = '0;
        if (rd_en && CYC_O && len_d != 16'hFFFF) len_d = len_d + 16'd1;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            len_q <= '0;
            end_q <= 1'b0;
        end else begin
            len_q <= len_d;
            end_q <= leave;
        end
    end

    assign FRM_LEN_O = len_q;
    assign FRM_END_O = end_q;
`endif

endmodule

// File: tb/tb_rx_dat_fifo.sv
// tb_rx_dat_fifo: randomized self-checking bench for rx_dat_fifo.
// A queue model tracks buffered bytes; a monitor rebuilds CYC_O envelopes.
module tb_rx_dat_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b1;
    logic [DW-1:0] DAT_I = '0;
    logic          WE_I  = 1'b0;
    logic          STB_I = 1'b0;
    logic          CYC_I = 1'b0;
    logic          ACK_O;
    logic [DW-1:0] DAT_O;
    logic          WE_O;
    logic          STB_O;
    logic          CYC_O;
    logic          ACK_I;
    logic          ack_en = 1'b0;
`ifdef RXDAT_FRMLEN_EN
    logic [15:0]   FRM_LEN_O;
    logic          FRM_END_O;
    int            end_cnt   = 0;
    int            last_strb = 0;
`endif

    // consumer behaves as a Wishbone slave: acks only inside CYC_O
    assign ACK_I = ack_en & CYC_O & STB_O;

    always #5 CLK_I = ~CLK_I;

    rx_dat_fifo #(.DW(DW), .AW(AW)) dut (
        .CLK_I(CLK_I),
        .RST_I(RST_I),
        .DAT_I(DAT_I),
        .WE_I(WE_I),
        .STB_I(STB_I),
        .CYC_I(CYC_I),
        .ACK_O(ACK_O),
        .DAT_O(DAT_O),
        .WE_O(WE_O),
        .STB_O(STB_O),
        .CYC_O(CYC_O),
`ifdef RXDAT_FRMLEN_EN
        .FRM_LEN_O(FRM_LEN_O),
        .FRM_END_O(FRM_END_O),
`endif
        .ACK_I(ACK_I)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mq[$];
    logic [7:0] tx[$];
    int env_strb[$];
    int env_hi[$];
    int env_low[$];
    int cur_strb = 0;
    int cur_hi   = 0;
    int low_run  = 0;
    bit in_env    = 0;
    bit seen_fall = 0;
    bit cyc_seen  = 0;
    int first_stall = -1;

    always @(negedge CLK_I) begin
        if (RST_I) begin
            in_env  = 0;
            cur_strb = 0;
            cur_hi  = 0;
        end else begin
            n_chk++;
            if (STB_O !== (mq.size() != 0)) begin
                n_fail++;
                $display("FAIL stb_vs_model got %b want %b", STB_O, mq.size() != 0);
            end
            n_chk++;
            if (ACK_O !== (mq.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL ack_vs_model got %b want %b", ACK_O, mq.size() < DEPTH);
            end
            if (CYC_O === 1'b1) begin
                cyc_seen = 1;
                if (!in_env) begin
                    in_env   = 1;
                    cur_strb = 0;
                    cur_hi   = 0;
                    if (seen_fall) env_low.push_back(low_run);
                end
                cur_hi++;
            end else begin
                if (in_env) begin
                    in_env = 0;
                    env_strb.push_back(cur_strb);
                    env_hi.push_back(cur_hi);
`ifdef RXDAT_FRMLEN_EN
                    last_strb = cur_strb;
`endif
                    seen_fall = 1;
                    low_run   = 0;
                end
                low_run++;
            end
            if (STB_O === 1'b1 && ACK_I === 1'b1) begin
                n_chk++;
                if (mq.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_empty_model got %h want none", DAT_O);
                end else begin
                    if (DAT_O !== mq[0]) begin
                        n_fail++;
                        $display("FAIL dat_order got %h want %h", DAT_O, mq[0]);
                    end
                    void'(mq.pop_front());
                end
                cur_strb++;
            end
`ifdef RXDAT_FRMLEN_EN
            if (FRM_END_O === 1'b1) begin
                end_cnt++;
                n_chk++;
                if (FRM_LEN_O !== 16'(last_strb)) begin
                    n_fail++;
                    $display("FAIL frm_len got %0d want %0d", FRM_LEN_O, last_strb);
                end
            end
`endif
        end
    end

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic clr_env();
        env_strb.delete();
        env_hi.delete();
        env_low.delete();
        seen_fall = 0;
    endtask

    task automatic send_frame(input bit rnd, input bit keep_cyc);
        int i = 0;
        int guard = 0;
        bit acc;
        CYC_I = 1'b1;
        if (tx.size() == 0) tick();
        while (i < tx.size() && guard < 2000) begin
            if (rnd) begin
                ack_en = ($urandom_range(0, 3) != 0);
                STB_I  = ($urandom_range(0, 4) != 0);
                WE_I   = ($urandom_range(0, 7) != 0);
            end else begin
                STB_I = 1'b1;
                WE_I  = 1'b1;
            end
            DAT_I = tx[i];
            acc = ACK_O & STB_I & WE_I;
            if (!ACK_O && first_stall < 0) first_stall = i;
            tick();
            if (acc) begin
                mq.push_back(tx[i]);
                i++;
            end
            guard++;
        end
        STB_I = 1'b0;
        WE_I  = 1'b0;
        if (!keep_cyc) CYC_I = 1'b0;
        if (guard >= 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout got %0d want %0d", i, tx.size());
        end
    endtask

    task automatic drain(input int lim);
        int k = 0;
        ack_en = 1'b1;
        while ((mq.size() != 0 || in_env) && k < lim) begin
            tick();
            k++;
        end
        repeat (3) tick();
        n_chk++;
        if (k >= lim) begin
            n_fail++;
            $display("FAIL drain_timeout got %0d want <%0d", k, lim);
        end
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if (ACK_O !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ack got %b want 1", ACK_O);
        end
        n_chk++;
        if (STB_O !== 1'b0 || WE_O !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stb got %b%b want 00", STB_O, WE_O);
        end
        n_chk++;
        if (CYC_O !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_cyc got %b want 0", CYC_O);
        end
        tick();
        tick();
        RST_I = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
`ifdef RXDAT_FRMLEN_EN
        int e0 = end_cnt;
`endif
        clr_env();
        ack_en = 1'b1;
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            DAT_I = 8'(i + 1);
            tick();
            mq.push_back(8'(i + 1));
            if (i == 0) begin
                n_chk++;
                if (STB_O !== 1'b1 || DAT_O !== 8'h01 || CYC_O !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fall_through got %b/%h/%b want 1/01/1",
                             STB_O, DAT_O, CYC_O);
                end
            end
        end
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        drain(100);
        n_chk++;
        if (env_strb.size() != 1) begin
            n_fail++;
            $display("FAIL single_env_cnt got %0d want 1", env_strb.size());
        end else begin
            n_chk++;
            if (env_strb[0] != 5 || env_hi[0] != 5) begin
                n_fail++;
                $display("FAIL single_env got %0d/%0d want 5/5",
                         env_strb[0], env_hi[0]);
            end
        end
`ifdef RXDAT_FRMLEN_EN
        n_chk++;
        if (end_cnt - e0 != 1 || FRM_LEN_O !== 16'd5) begin
            n_fail++;
            $display("FAIL single_frmlen got %0d/%0d want 1/5",
                     end_cnt - e0, FRM_LEN_O);
        end
`endif
    endtask

    task automatic test_full();
        clr_env();
        ack_en = 1'b0;
        first_stall = -1;
        tx.delete();
        for (int i = 0; i < 20; i++) tx.push_back(8'($urandom_range(0, 255)));
        fork
            send_frame(1'b0, 1'b0);
            begin
                int k = 0;
                while (first_stall < 0 && k < 200) begin
                    tick();
                    k++;
                end
                n_chk++;
                if (first_stall != 16 || ACK_O !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_stall got %0d/%b want 16/0",
                             first_stall, ACK_O);
                end
                repeat (3) tick();
                ack_en = 1'b1;
            end
        join
        drain(200);
        n_chk++;
        if (env_strb.size() != 1) begin
            n_fail++;
            $display("FAIL full_env_cnt got %0d want 1", env_strb.size());
        end else begin
            n_chk++;
            if (env_strb[0] != 20) begin
                n_fail++;
                $display("FAIL full_env_len got %0d want 20", env_strb[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clr_env();
        ack_en = 1'b0;
        tx = '{8'hA1, 8'hA2, 8'hA3};
        send_frame(1'b0, 1'b0);
        tick();
        tx = '{8'hB1, 8'hB2};
        send_frame(1'b0, 1'b0);
        tick();
        drain(100);
        n_chk++;
        if (env_strb.size() != 2 || env_low.size() != 1) begin
            n_fail++;
            $display("FAIL b2b_env_cnt got %0d/%0d want 2/1",
                     env_strb.size(), env_low.size());
        end else begin
            n_chk++;
            if (env_strb[0] != 3 || env_strb[1] != 2) begin
                n_fail++;
                $display("FAIL b2b_env_len got %0d,%0d want 3,2",
                         env_strb[0], env_strb[1]);
            end
            n_chk++;
            if (env_low[0] != 1) begin
                n_fail++;
                $display("FAIL b2b_gap got %0d want 1", env_low[0]);
            end
        end
    endtask

    task automatic test_idle_hold();
        clr_env();
        ack_en = 1'b1;
        tx.delete();
        for (int i = 0; i < 4; i++) tx.push_back(8'($urandom_range(0, 255)));
        send_frame(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_chk++;
            if (CYC_O !== 1'b1 || STB_O !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold got %b/%b want 1/0", CYC_O, STB_O);
            end
        end
        CYC_I = 1'b0;
        #1;
        n_chk++;
        if (CYC_O !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_pre_fall got %b want 1", CYC_O);
        end
        tick();
        n_chk++;
        if (CYC_O !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_fall got %b want 0", CYC_O);
        end
        drain(50);
        n_chk++;
        if (env_strb.size() != 1 || (env_strb.size() == 1 && env_strb[0] != 4)) begin
            n_fail++;
            $display("FAIL idle_env got %0d envs want 1x4", env_strb.size());
        end
    endtask

    task automatic test_empty_reset();
        clr_env();
        cyc_seen = 0;
        CYC_I = 1'b1;
        repeat (3) tick();
        CYC_I = 1'b0;
        repeat (4) tick();
        n_chk++;
        if (cyc_seen || STB_O !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_frame got %b/%b want 0/0", cyc_seen, STB_O);
        end
        ack_en = 1'b0;
        tx.delete();
        for (int i = 0; i < 6; i++) tx.push_back(8'($urandom_range(0, 255)));
        send_frame(1'b0, 1'b1);
        n_chk++;
        if (STB_O !== 1'b1 || CYC_O !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst got %b/%b want 1/1", STB_O, CYC_O);
        end
        RST_I = 1'b1;
        CYC_I = 1'b0;
        mq.delete();
        #1;
        n_chk++;
        if (STB_O !== 1'b0 || CYC_O !== 1'b0 || ACK_O !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst got %b/%b/%b want 0/0/1",
                     STB_O, CYC_O, ACK_O);
        end
        tick();
        RST_I = 1'b0;
        tick();
        clr_env();
        ack_en = 1'b1;
        tx = '{8'h5A, 8'hC3, 8'h0F};
        send_frame(1'b0, 1'b0);
        drain(50);
        n_chk++;
        if (env_strb.size() != 1 || (env_strb.size() == 1 && env_strb[0] != 3)) begin
            n_fail++;
            $display("FAIL post_rst_env got %0d envs want 1x3", env_strb.size());
        end
    endtask

    task automatic test_random();
        int exp_len[$];
`ifdef RXDAT_FRMLEN_EN
        int e0 = end_cnt;
`endif
        clr_env();
        for (int f = 0; f < 14; f++) begin
            int len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24));
            tx.delete();
            for (int j = 0; j < len; j++) tx.push_back(8'($urandom_range(0, 255)));
            if (len > 0) exp_len.push_back(len);
            send_frame(1'b1, 1'b0);
            repeat ($urandom_range(1, 3)) begin
                ack_en = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        drain(400);
        n_chk++;
        if (env_strb.size() != exp_len.size()) begin
            n_fail++;
            $display("FAIL rnd_env_cnt got %0d want %0d",
                     env_strb.size(), exp_len.size());
        end else begin
            foreach (exp_len[k]) begin
                n_chk++;
                if (env_strb[k] != exp_len[k]) begin
                    n_fail++;
                    $display("FAIL rnd_env_len[%0d] got %0d want %0d",
                             k, env_strb[k], exp_len[k]);
                end
            end
        end
`ifdef RXDAT_FRMLEN_EN
        n_chk++;
        if (end_cnt - e0 != exp_len.size()) begin
            n_fail++;
            $display("FAIL rnd_end_pulses got %0d want %0d",
                     end_cnt - e0, exp_len.size());
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_full();
        test_back_to_back();
        test_idle_hold();
        test_empty_reset();
        test_random();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/rx_dat_fifo.md
# rx_dat_fifo

Elastic output buffer on the receive byte stream at the output of the OFDM RX chain. It sits between the demodulated 8-bit `DAT_O` Wishbone-style master port of the receiver and the downstream byte consumer (host or MAC). It absorbs consumer back-pressure without stalling the receiver. It also regenerates frame framing on `CYC_O`: `CYC_O` drops for at least one cycle after the last byte of each frame.

## Interface
- `DW`, 8: data width, bits.
- `AW`, 4: address width; depth = 2^AW entries.
- `CLK_I` in 1: clock.
- `RST_I` in 1: reset, asynchronous, active-high.
- `DAT_I` in DW: write data from the receiver.
- `WE_I` in 1: write-enable qualifier; a write is accepted only with `WE_I`=1.
- `STB_I` in 1: write strobe.
- `CYC_I` in 1: input frame envelope; high for the duration of a frame.
- `ACK_O` out 1: ready; equals `~full`.
- `DAT_O` out DW: head-of-FIFO data.
- `WE_O` out 1: equals `STB_O`.
- `STB_O` out 1: data valid; equals `~empty`.
- `CYC_O` out 1: output frame envelope.
- `ACK_I` in 1: consumer accept.

## Operation
- Write: when `CYC_I & STB_I & WE_I & ACK_O`, store `DAT_I` at `wr_ptr`, clear `tag[wr_ptr]`, advance `wr_ptr`, and set `frm_has_data`.
- Read: when `STB_O & ACK_I`, advance `rd_ptr`. `DAT_O = mem[rd_ptr]` (registered array, combinational read).
- Pointers are AW+1 bits wide.
  - empty when pointers are equal.
  - full when the MSBs differ and the low bits are equal.
  - Pointers wrap modulo 2^(AW+1).
- Frame close: falling edge of `CYC_I` (`cyc_d & ~CYC_I`), with `frm_has_data`=1.
  - If the last written entry is still held (not empty, or a write-side byte remains unread), set `tag[wr_ptr-1]`=1.
  - Otherwise the last byte has already been drained: set `end_pend`=1.
  - In both cases clear `frm_has_data`.
- A frame close with `frm_has_data`=0 is ignored; no envelope is generated for a zero-length frame.
- Output FSM, states O_IDLE and O_FRM:
  - O_IDLE -> O_FRM when `STB_O`=1; `CYC_O` goes high in the same cycle (combinational from state/next).
  - O_FRM -> O_IDLE in either case:
    - a read pops an entry with `tag`=1;
    - `end_pend`=1, which is then cleared.
  - In O_FRM with the FIFO empty and no end seen, `CYC_O` stays high with `STB_O`=0 (gap inside a frame).
  - After leaving O_FRM, `CYC_O` is forced low for exactly 1 cycle (`gap` flag), even if `STB_O`=1.
- Simultaneous events:
  - Read and write in the same cycle while full: the write is rejected (`ACK_O`=0 was sampled).
  - Read and write in the same cycle while empty: the read is not possible (`STB_O`=0); the write proceeds.
  - Frame close in the same cycle as the read of the last written entry: treated as already drained, so set `end_pend`.
- `STB_I` without `CYC_I` is ignored.

## Timing
- Reset values: `ACK_O`=1, `STB_O`=0, `WE_O`=0, `CYC_O`=0, `DAT_O`=mem[0] (don't care), pointers 0, all tags 0, `end_pend`=0, state O_IDLE.
- Fall-through latency: a byte written at edge N is visible on `STB_O`/`DAT_O` after edge N; it is first acceptable at edge N+1.
- Throughput: 1 byte/cycle sustained with both sides ready.
- `ACK_O` deasserts in the cycle after the write that fills the FIFO.
- `CYC_O` falls the cycle after the last tagged byte is accepted. It stays low ≥1 cycle.
- Reset mid-frame: buffer contents are discarded and all outputs return to their reset values immediately (asynchronous).

## Configuration
- `RXDAT_FRMLEN_EN` defined:
  - Adds output `FRM_LEN_O` (16 bits): the count of bytes read in the current output frame. It is held after the frame ends and cleared on the next O_IDLE->O_FRM transition.
  - Adds output `FRM_END_O` (1 bit): a one-cycle pulse on every O_FRM->O_IDLE transition.
  - The counter saturates at 16'hFFFF.
- Not defined: both ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset with `ACK_I`=1; write a 5-byte frame 01..05 at 1 byte/cycle -> `DAT_O` 01..05 on consecutive cycles; `CYC_O` high for 5 cycles, then low for ≥1 cycle. With the macro: `FRM_LEN_O`=5 and a `FRM_END_O` pulse.
- `ACK_I`=0; write 20 bytes with AW=4 -> `ACK_O` falls after the 16th accepted byte. Raise `ACK_I` -> all 20 bytes come out in order; exactly one `CYC_O` envelope.
- Frame A (3 bytes), then frame B (2 bytes) written back-to-back with a 1-cycle `CYC_I` gap, `ACK_I`=0 until both are written -> two `CYC_O` envelopes (3 and 2 strobes) separated by exactly one low cycle.
- `ACK_I`=1; write 4 bytes, then hold `CYC_I` high idle for 10 cycles before dropping it -> `CYC_O` stays high with `STB_O`=0 during the idle, and falls 1 cycle after `CYC_I` falls (`end_pend` path).
- Pulse `CYC_I` with no `STB_I` -> `CYC_O` never rises. Then assert `RST_I` mid-frame with 6 bytes buffered -> `STB_O`=0 and `CYC_O`=0 immediately; the next frame starts clean.
